// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the ws2812 write scheduler: widths, FSM states,
// requester IDs and the per-byte brightness scaler.
package ws2812_pkg;

  localparam int RGB_W = 24;
  localparam int LED_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // out = (c * (br + 1)) >> 8; br = 255 is identity, br = 0 yields 0.
  function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] br);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, br} + 16'd1);
    return prod[15:8];
  endfunction

  function automatic logic [RGB_W-1:0] scale_rgb(input logic [RGB_W-1:0] c, input logic [7:0] br);
    return {scale_byte(c[23:16], br), scale_byte(c[15:8], br), scale_byte(c[7:0], br)};
  endfunction

endpackage

// File: rtl/ws2812_write_scheduler_if.sv
// Pixel requester bundle for the ws2812 write scheduler (requesters A and B).
// A transfer happens in a cycle where x_valid and x_ready are both high; once
// x_valid is raised, x_valid/x_led/x_rgb stay stable until that cycle.
interface ws2812_write_scheduler_if;
  import ws2812_pkg::*;

  logic             a_valid;
  logic [LED_W-1:0] a_led;
  logic [RGB_W-1:0] a_rgb;
  logic             a_ready;
  logic             b_valid;
  logic [LED_W-1:0] b_led;
  logic [RGB_W-1:0] b_rgb;
  logic             b_ready;

  modport master (
    output a_valid, a_led, a_rgb, b_valid, b_led, b_rgb,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_led, a_rgb, b_valid, b_led, b_rgb,
    output a_ready, b_ready
  );

endinterface

// File: rtl/ws2812_rr_arbiter.sv
// Two-way round-robin arbiter: a lone valid wins outright, a tie goes to the
// requester named by rr_ptr, and each accept hands priority to the loser.
module ws2812_rr_arbiter
  import ws2812_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       accept,
  output logic [1:0] grant,
  output req_id_t    rr_ptr
);

  req_id_t rr_ptr_q;
  req_id_t rr_ptr_d;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (rr_ptr_q == REQ_A) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && (grant != 2'b00)) begin
      rr_ptr_d = grant[0] ? REQ_B : REQ_A;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= REQ_A;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr = rr_ptr_q;

endmodule

// File: rtl/ws2812_write_scheduler.sv
// Owns the ws2812 driver's write port: arbitrates two pixel requesters and runs
// a whole-strip fill sequencer. Optional WS2812_BRIGHTNESS_EN adds output scaling.
module ws2812_write_scheduler
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  ws2812_write_scheduler_if.slave req,
  input  logic             fill_start,
  input  logic [RGB_W-1:0] fill_rgb,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]       brightness,
`endif
  output logic             busy,
  output logic             drop,
  output logic             write,
  output logic [LED_W-1:0] led_num,
  output logic [RGB_W-1:0] rgb_data,
  output state_t           dbg_state,
  output req_id_t          dbg_rr_ptr
);

  localparam logic [8:0] NUM_LEDS_W = 9'(NUM_LEDS);
  localparam logic [8:0] LAST_IDX   = 9'(NUM_LEDS - 1);

  state_t           state_q,    state_d;
  logic [8:0]       fill_idx_q, fill_idx_d;
  logic [RGB_W-1:0] fill_rgb_q, fill_rgb_d;
  logic             write_q,    write_d;
  logic [LED_W-1:0] led_num_q,  led_num_d;
  logic [RGB_W-1:0] rgb_data_q, rgb_data_d;
  logic             busy_q,     busy_d;
  logic             drop_q,     drop_d;

  logic [1:0]       grant;
  logic             arb_enable;
  logic [LED_W-1:0] sel_led;
  logic [RGB_W-1:0] sel_rgb;
  logic             in_range;
  logic             issue;
  logic [RGB_W-1:0] rgb_src;
  logic [RGB_W-1:0] rgb_scaled;

  // A fill request in IDLE outranks both pixel requesters.
  assign arb_enable = (state_q == ST_IDLE) && !fill_start;

  ws2812_rr_arbiter u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   ({req.b_valid, req.a_valid}),
    .enable  (arb_enable),
    .accept  (|grant),
    .grant   (grant),
    .rr_ptr  (dbg_rr_ptr)
  );

  assign req.a_ready = grant[0];
  assign req.b_ready = grant[1];

  assign sel_led  = grant[1] ? req.b_led : req.a_led;
  assign sel_rgb  = grant[1] ? req.b_rgb : req.a_rgb;
  assign in_range = ({1'b0, sel_led} < NUM_LEDS_W);

  always_comb begin
    state_d    = state_q;
    fill_idx_d = fill_idx_q;
    fill_rgb_d = fill_rgb_q;
    write_d    = 1'b0;
    led_num_d  = led_num_q;
    busy_d     = 1'b0;
    drop_d     = 1'b0;
    issue      = 1'b0;
    rgb_src    = fill_rgb_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          fill_rgb_d = fill_rgb;
          fill_idx_d = 9'd0;
          state_d    = ST_FILL;
        end else if (grant != 2'b00) begin
          // Out-of-range requests are still handshaken so the requester never stalls.
          if (in_range) begin
            write_d   = 1'b1;
            led_num_d = sel_led;
            rgb_src   = sel_rgb;
            issue     = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        write_d    = 1'b1;
        busy_d     = 1'b1;
        led_num_d  = fill_idx_q[LED_W-1:0];
        rgb_src    = fill_rgb_q;
        issue      = 1'b1;
        fill_idx_d = fill_idx_q + 9'd1;
        if (fill_idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef WS2812_BRIGHTNESS_EN
  assign rgb_scaled = scale_rgb(rgb_src, brightness);
`else
  assign rgb_scaled = rgb_src;
`endif

  // Colour lines hold their last written value while write is low.
  assign rgb_data_d = issue ? rgb_scaled : rgb_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      fill_idx_q <= '0;
      fill_rgb_q <= '0;
      write_q    <= 1'b0;
      led_num_q  <= '0;
      rgb_data_q <= '0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_idx_q <= fill_idx_d;
      fill_rgb_q <= fill_rgb_d;
      write_q    <= write_d;
      led_num_q  <= led_num_d;
      rgb_data_q <= rgb_data_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  assign write     = write_q;
  assign led_num   = led_num_q;
  assign rgb_data  = rgb_data_q;
  assign busy      = busy_q;
  assign drop      = drop_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ws2812_write_scheduler.sv
// Self-checking bench for ws2812_write_scheduler: scenario tasks plus a random
// run, all checked against a transaction-level model of the scheduling rules.
module tb_ws2812_write_scheduler;
  import ws2812_pkg::*;

  localparam int NUM_LEDS = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ws2812_write_scheduler_if req_if ();

  logic        fill_start;
  logic [23:0] fill_rgb;
  logic        busy, drop, write;
  logic [7:0]  led_num;
  logic [23:0] rgb_data;
  state_t      dbg_state;
  req_id_t     dbg_rr_ptr;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]  brightness;
`endif

  ws2812_write_scheduler #(.NUM_LEDS(NUM_LEDS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req_if),
    .fill_start (fill_start),
    .fill_rgb   (fill_rgb),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .busy       (busy),
    .drop       (drop),
    .write      (write),
    .led_num    (led_num),
    .rgb_data   (rgb_data),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  int          m_fill_left;
  int          m_fill_led;
  logic [23:0] m_fill_rgb;
  int          m_rr;             // 0 = A has priority on a tie, 1 = B
  logic [1:0]  exp_rdy;          // {a_ready, b_ready}
  logic [34:0] exp_out;          // {write, busy, drop, led, rgb}
  logic [31:0] exp_q[$];         // expected {led, rgb} of every write, in order

  logic [1:0]  obs_rdy;
  logic [34:0] obs_out;

  function automatic logic [34:0] pack(input logic w, input logic b, input logic d,
                                       input logic [7:0] l, input logic [23:0] c);
    return w ? {w, b, d, l, c} : {w, b, d, 8'd0, 24'd0};
  endfunction

  function automatic logic [23:0] mscale(input logic [23:0] c);
`ifdef WS2812_BRIGHTNESS_EN
    int k;
    logic [23:0] r;
    k = int'(brightness) + 1;
    r[23:16] = 8'((int'(c[23:16]) * k) / 256);
    r[15:8]  = 8'((int'(c[15:8])  * k) / 256);
    r[7:0]   = 8'((int'(c[7:0])   * k) / 256);
    return r;
`else
    return c;
`endif
  endfunction

  task automatic model_reset();
    m_fill_left = 0;
    m_fill_led  = 0;
    m_fill_rgb  = '0;
    m_rr        = 0;
  endtask

  // Decide this cycle's handshake and the write that must appear after the edge.
  task automatic model_eval();
    int g;
    logic [7:0]  l;
    logic [23:0] c;
    exp_rdy = 2'b00;
    exp_out = '0;
    if (m_fill_left > 0) begin
      c = mscale(m_fill_rgb);
      exp_out = pack(1'b1, 1'b1, 1'b0, 8'(m_fill_led), c);
      exp_q.push_back({8'(m_fill_led), c});
      m_fill_led++;
      m_fill_left--;
    end else if (fill_start) begin
      m_fill_left = NUM_LEDS;
      m_fill_led  = 0;
      m_fill_rgb  = fill_rgb;
    end else begin
      g = -1;
      if (req_if.a_valid && req_if.b_valid) g = m_rr;
      else if (req_if.a_valid) g = 0;
      else if (req_if.b_valid) g = 1;
      if (g >= 0) begin
        exp_rdy = (g == 0) ? 2'b10 : 2'b01;
        m_rr = 1 - g;
        l = (g == 0) ? req_if.a_led : req_if.b_led;
        c = mscale((g == 0) ? req_if.a_rgb : req_if.b_rgb);
        if (int'(l) < NUM_LEDS) begin
          exp_out = pack(1'b1, 1'b0, 1'b0, l, c);
          exp_q.push_back({l, c});
        end else begin
          exp_out = pack(1'b0, 1'b0, 1'b1, 8'd0, 24'd0);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    req_if.a_valid = 1'b0; req_if.a_led = '0; req_if.a_rgb = '0;
    req_if.b_valid = 1'b0; req_if.b_led = '0; req_if.b_rgb = '0;
    fill_start = 1'b0;
    fill_rgb   = '0;
`ifdef WS2812_BRIGHTNESS_EN
    brightness = 8'd255;
`endif
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Entered at posedge+1 with inputs set; samples readies before the edge and
  // registered outputs just after it.
  task automatic cycle();
    #3;
    model_eval();
    obs_rdy = {req_if.a_ready, req_if.b_ready};
    @(posedge clk);
    #1;
    obs_out = pack(write, busy, drop, led_num, rgb_data);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    #3;
    n_cmp++;
    if ({write, busy, drop, led_num, rgb_data} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {write, busy, drop, led_num, rgb_data});
    end
    n_cmp++;
    if ({req_if.a_ready, req_if.b_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 00", {req_if.a_ready, req_if.b_ready});
    end
    n_cmp++;
    if ({dbg_state, dbg_rr_ptr} !== {ST_IDLE, REQ_A}) begin
      n_fail++;
      $display("FAIL reset_state: got %b want 00", {dbg_state, dbg_rr_ptr});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    apply_reset();
    req_if.a_valid = 1'b1; req_if.a_led = 8'd3; req_if.a_rgb = 24'h00FF00;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL single_ready[%0d]: got %b want %b", i, obs_rdy, exp_rdy);
      end
      n_cmp++;
      if (obs_out !== exp_out) begin
        n_fail++;
        $display("FAIL single_out[%0d]: got %h want %h", i, obs_out, exp_out);
      end
      req_if.a_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want_led;
    apply_reset();
    req_if.a_valid = 1'b1; req_if.a_led = 8'd1; req_if.a_rgb = 24'($urandom);
    req_if.b_valid = 1'b1; req_if.b_led = 8'd2; req_if.b_rgb = 24'($urandom);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        req_if.a_valid = 1'b0;
        req_if.b_valid = 1'b0;
      end
      cycle();
      n_cmp++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: got %b want %b", i, obs_rdy, exp_rdy);
      end
      n_cmp++;
      if (obs_out !== exp_out) begin
        n_fail++;
        $display("FAIL b2b_out[%0d]: got %h want %h", i, obs_out, exp_out);
      end
      if (i < 4) begin
        want_led = (i % 2 == 0) ? 8'd1 : 8'd2;
        n_cmp++;
        if ({write, led_num} !== {1'b1, want_led}) begin
          n_fail++;
          $display("FAIL b2b_led[%0d]: got %b/%0d want 1/%0d", i, write, led_num, want_led);
        end
      end
    end
  endtask

  task automatic test_fill_priority();
    apply_reset();
    fill_start = 1'b1; fill_rgb = 24'h102030;
    req_if.a_valid = 1'b1; req_if.a_led = 8'd5; req_if.a_rgb = 24'hABCDEF;
    for (int i = 0; i < NUM_LEDS + 3; i++) begin
      // A second start in the middle of a fill must be ignored.
      fill_start = (i == 0) || (i == 4);
      fill_rgb   = (i == 0) ? 24'h102030 : 24'h777777;
      if (i == NUM_LEDS + 2) req_if.a_valid = 1'b0;
      cycle();
      n_cmp++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL fill_ready[%0d]: got %b want %b", i, obs_rdy, exp_rdy);
      end
      n_cmp++;
      if (obs_out !== exp_out) begin
        n_fail++;
        $display("FAIL fill_out[%0d]: got %h want %h", i, obs_out, exp_out);
      end
      if (i >= 1 && i <= NUM_LEDS) begin
        n_cmp++;
        if ({write, busy, led_num, rgb_data} !== {1'b1, 1'b1, 8'(i - 1), 24'h102030}) begin
          n_fail++;
          $display("FAIL fill_seq[%0d]: got %b%b/%0d/%h want 11/%0d/102030",
                   i, write, busy, led_num, rgb_data, i - 1);
        end
      end
    end
    fill_start = 1'b0;
  endtask

  task automatic test_drop();
    apply_reset();
    req_if.a_valid = 1'b1; req_if.a_led = 8'(NUM_LEDS); req_if.a_rgb = 24'h123456;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        req_if.a_led = 8'd4;
        req_if.b_valid = 1'b1; req_if.b_led = 8'd6; req_if.b_rgb = 24'h654321;
      end
      if (i == 3) begin
        req_if.a_valid = 1'b0;
        req_if.b_valid = 1'b0;
      end
      cycle();
      n_cmp++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL drop_ready[%0d]: got %b want %b", i, obs_rdy, exp_rdy);
      end
      n_cmp++;
      if (obs_out !== exp_out) begin
        n_fail++;
        $display("FAIL drop_out[%0d]: got %h want %h", i, obs_out, exp_out);
      end
      n_cmp++;
      if (int'(dbg_rr_ptr) !== m_rr) begin
        n_fail++;
        $display("FAIL drop_rr[%0d]: got %0d want %0d", i, dbg_rr_ptr, m_rr);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    apply_reset();
    fill_start = 1'b1; fill_rgb = 24'h0A0B0C;
    cycle();
    fill_start = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    n_cmp++;
    if ({write, led_num} !== {1'b1, 8'd3}) begin
      n_fail++;
      $display("FAIL midfill_pre: got %b/%0d want 1/3", write, led_num);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({write, busy, drop, led_num, rgb_data, dbg_state} !== 36'd0) begin
      n_fail++;
      $display("FAIL midfill_async: got %h want 0", {write, busy, drop, led_num, rgb_data});
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    exp_q.delete();
    for (int i = 0; i < NUM_LEDS + 2; i++) begin
      cycle();
      n_cmp++;
      if (obs_out !== exp_out || write !== 1'b0) begin
        n_fail++;
        $display("FAIL midfill_after[%0d]: got %h want %h", i, obs_out, exp_out);
      end
    end
  endtask

`ifdef WS2812_BRIGHTNESS_EN
  task automatic test_brightness();
    apply_reset();
    brightness = 8'd127;
    req_if.a_valid = 1'b1; req_if.a_led = 8'd2; req_if.a_rgb = 24'hFF8001;
    cycle();
    req_if.a_valid = 1'b0;
    n_cmp++;
    if ({write, rgb_data} !== {1'b1, 24'h7F4000}) begin
      n_fail++;
      $display("FAIL bright_127: got %b/%h want 1/7f4000", write, rgb_data);
    end
    brightness = 8'd255;
  endtask
`endif

  task automatic test_random();
    logic [31:0] got, want;
    int budget;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (!req_if.a_valid && $urandom_range(0, 2) != 0) begin
        req_if.a_valid = 1'b1;
        req_if.a_led = 8'($urandom_range(0, NUM_LEDS + 1));
        req_if.a_rgb = 24'($urandom);
      end
      if (!req_if.b_valid && $urandom_range(0, 2) != 0) begin
        req_if.b_valid = 1'b1;
        req_if.b_led = 8'($urandom_range(0, NUM_LEDS + 1));
        req_if.b_rgb = 24'($urandom);
      end
      fill_start = ($urandom_range(0, 39) == 0);
      fill_rgb = 24'($urandom);
`ifdef WS2812_BRIGHTNESS_EN
      brightness = 8'($urandom);
`endif
      cycle();
      n_cmp++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_ready[%0d]: got %b want %b", i, obs_rdy, exp_rdy);
      end
      n_cmp++;
      if (obs_out[34:32] !== exp_out[34:32]) begin
        n_fail++;
        $display("FAIL rand_flags[%0d]: got %b want %b", i, obs_out[34:32], exp_out[34:32]);
      end
      if (write) begin
        got = {led_num, rgb_data};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_write[%0d]: got %h want none", i, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL rand_write[%0d]: got %h want %h", i, got, want);
          end
        end
      end
      if (obs_rdy[1]) req_if.a_valid = 1'b0;
      if (obs_rdy[0]) req_if.b_valid = 1'b0;
    end
    clear_inputs();
    budget = NUM_LEDS + 4;
    while (m_fill_left > 0 && budget > 0) begin
      cycle();
      budget--;
      if (write && exp_q.size() > 0) begin
        got = {led_num, rgb_data};
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL rand_drain: got %h want %h", got, want);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_leftover: got %0d pending want 0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_priority();
    test_drop();
    test_reset_mid_fill();
`ifdef WS2812_BRIGHTNESS_EN
    test_brightness();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
